// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the round-robin RAM arbiter.
package mem_arb_pkg;

  // Transaction phases: grant/issue, optional read latency wait, response pulse.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam int unsigned DefaultAw = 8;
  localparam int unsigned DefaultDw = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first requester after `last`.
module rr_pick #(
  parameter int unsigned NCORES = 2,
  localparam int unsigned IdxW = $clog2(NCORES)
) (
  input  logic [NCORES-1:0] req,
  input  logic [IdxW-1:0]   last,
  output logic [NCORES-1:0] win,
  output logic [IdxW-1:0]   win_idx
);

  // Scan from last+1 modulo NCORES; the first set bit wins.
  always_comb begin
    logic        found;
    int unsigned idx;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned off = 1; off <= NCORES; off++) begin
      idx = (int'(last) + off) % NCORES;
      if (!found && req[idx]) begin
        found        = 1'b1;
        win[idx]     = 1'b1;
        win_idx      = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NCORES cores.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NCORES = 2,
  parameter int unsigned AW     = DefaultAw,
  parameter int unsigned DW     = DefaultDw,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES-1:0]    we,
  input  logic [NCORES*AW-1:0] addr,
  input  logic [NCORES*DW-1:0] wdata,
  output logic [NCORES-1:0]    gnt,
  output logic [NCORES-1:0]    done,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_din,
  output logic                 ram_wren,
  input  logic [DW-1:0]        ram_q
);

  localparam int unsigned IdxW = $clog2(NCORES);
  localparam int unsigned CntW = $clog2(RD_LAT + 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [NCORES-1:0]   gnt_q, gnt_d;
  logic [NCORES-1:0]   done_q, done_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       din_q, din_d;
  logic                wren_q, wren_d;
  logic                we_q, we_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic [NCORES-1:0]   win;
  logic [IdxW-1:0]     win_idx;

  rr_pick #(
    .NCORES (NCORES)
  ) u_pick (
    .req     (req),
    .last    (last_q),
    .win     (win),
    .win_idx (win_idx)
  );

  // Next-state logic: FSM, command latch and read-latency counter.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wren_d  = 1'b0;
    we_d    = we_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StIssue;
          gnt_d   = win;
          last_d  = win_idx;
          we_d    = we[win_idx];
          wren_d  = we[win_idx];
          addr_d  = addr[win_idx*AW +: AW];
          din_d   = wdata[win_idx*DW +: DW];
        end
      end
      StIssue: begin
        if (we_q || RD_LAT == 1) begin
          state_d = StResp;
          done_d  = gnt_q;
        end else begin
          state_d = StWait;
          cnt_d   = CntW'(RD_LAT - 1);
        end
      end
      StWait: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StResp;
          done_d  = gnt_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
        gnt_d   = '0;
        if (!we_q) rdata_d = ram_q;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= IdxW'(NCORES - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wren_q  <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wren_q  <= wren_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM output is registered inside the RAM and stable for the whole RESP cycle,
  // so it is forwarded directly there and held in rdata_q afterwards.
  always_comb begin
    rdata = rdata_q;
    if (state_q == StResp && !we_q) rdata = ram_q;
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = (state_q != StIdle);
  assign ram_addr = addr_q;
  assign ram_din  = din_q;
  assign ram_wren = wren_q;

endmodule
